// File: rtl/code_pkg.sv
// Shared types and default sizing for the code strobe generator.
package code_pkg;

    localparam int CNT_W         = 16;
    localparam int GAP_W         = 8;
    localparam int PRESCALE_LOG2 = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/code_down_counter.sv
// Loadable down counter with a zero flag; holds at zero.
module code_down_counter #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/code_strobe_gen.sv
// Turns a (channel, count, gap) request into single-cycle En_o strobes
// so a downstream En/Slt counter advances by exactly the requested count.
module code_strobe_gen #(
    parameter int CNT_W         = code_pkg::CNT_W,
    parameter int GAP_W         = code_pkg::GAP_W,
    parameter int PRESCALE_LOG2 = code_pkg::PRESCALE_LOG2
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Req_valid,
    output logic                           Req_ready,
    input  logic                           Req_slt,
    input  logic [CNT_W-1:0]               Req_count,
    input  logic [GAP_W-1:0]               Req_gap,
    input  logic                           Abort,
    output logic                           En_o,
    output logic                           Slt_o,
    output logic                           Busy,
    output logic                           Done,
    output logic [CNT_W+PRESCALE_LOG2-1:0] Emitted
);

    import code_pkg::*;

    localparam int TW = CNT_W + PRESCALE_LOG2;

    state_e           state_q;
    state_e           state_d;
    logic [GAP_W-1:0] gap_q;
    logic [TW-1:0]    cnt_ext;
    logic [TW-1:0]    total;
    logic             accept;
    logic             rem_zero;
    logic             gap_zero;
    logic             rem_dec;
    logic             gap_load;
    logic             gap_dec;

    assign Req_ready = (state_q == IDLE) && !Reset;
    assign accept    = Req_valid && Req_ready;
    assign cnt_ext   = TW'(Req_count);
    assign total     = Req_slt ? (cnt_ext << PRESCALE_LOG2) : cnt_ext;

    // Remaining counter holds strobes still owed after the current one.
    assign rem_dec  = (state_q == EMIT) && !rem_zero;
    assign gap_load = (state_q == EMIT) && !rem_zero && (gap_q != '0);
    assign gap_dec  = (state_q == GAP);

    code_down_counter #(.W(TW)) u_rem (
        .Clk    (Clk),
        .Reset  (Reset),
        .load_i (accept),
        .dec_i  (rem_dec),
        .val_i  (total - TW'(1)),
        .zero_o (rem_zero)
    );

    code_down_counter #(.W(GAP_W)) u_gap (
        .Clk    (Clk),
        .Reset  (Reset),
        .load_i (gap_load),
        .dec_i  (gap_dec),
        .val_i  (gap_q - GAP_W'(1)),
        .zero_o (gap_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)
                    state_d = (total == '0) ? DONE : EMIT;
            end
            EMIT: begin
                if (rem_zero)
                    state_d = DONE;
                else if (gap_q == '0)
                    state_d = EMIT;
                else
                    state_d = GAP;
            end
            GAP: begin
                if (gap_zero)
                    state_d = EMIT;
            end
            DONE: state_d = IDLE;
        endcase
        if (Abort && (state_q != IDLE))
            state_d = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            gap_q   <= '0;
            En_o    <= 1'b0;
            Slt_o   <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Emitted <= '0;
        end else begin
            state_q <= state_d;
            En_o    <= (state_d == EMIT);
            Busy    <= (state_d != IDLE);
            Done    <= (state_d == DONE);
            if (accept) begin
                gap_q   <= Req_gap;
                Slt_o   <= Req_slt;
                Emitted <= '0;
            end else if (state_q == EMIT) begin
                Emitted <= Emitted + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_code_strobe_gen.sv
// Randomized bench for code_strobe_gen against a cycle-schedule model.
module tb_code_strobe_gen;

    localparam int CW = 16;
    localparam int GW = 8;
    localparam int PL = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Req_valid = 1'b0;
    logic          Req_ready;
    logic          Req_slt = 1'b0;
    logic [CW-1:0] Req_count = '0;
    logic [GW-1:0] Req_gap = '0;
    logic          Abort = 1'b0;
    logic          En_o;
    logic          Slt_o;
    logic          Busy;
    logic          Done;
    logic [CW+PL-1:0] Emitted;

    code_strobe_gen #(.CNT_W(CW), .GAP_W(GW), .PRESCALE_LOG2(PL)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_valid (Req_valid),
        .Req_ready (Req_ready),
        .Req_slt   (Req_slt),
        .Req_count (Req_count),
        .Req_gap   (Req_gap),
        .Abort     (Abort),
        .En_o      (En_o),
        .Slt_o     (Slt_o),
        .Busy      (Busy),
        .Done      (Done),
        .Emitted   (Emitted)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the current request as a schedule of cycle numbers
    longint cyc = 0;
    bit     rmode = 1'b1;
    longint mk = -10, mT = 0, mg = 0, mdone = -10, mend = -10;
    bit     mslt = 1'b0;
    bit     run = 1'b1;

    // observed statistics, used by the directed literal checks
    int     acc_n = 0;
    longint acc_cyc = -1;
    longint first_en = -1;
    longint done_cyc = -1;
    int     en_n = 0;
    int     s0 = 0;
    int     s1 = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (run) begin
            bit     busy_m, e_en, e_done, e_rdy;
            longint e_emit, m;
            busy_m = !rmode && (cyc > mk) && (cyc <= mend);
            e_en   = 1'b0;
            e_done = 1'b0;
            e_emit = 0;
            if (!rmode) begin
                e_done = busy_m && (cyc == mdone);
                e_en   = busy_m && (cyc < mdone) &&
                         (((cyc - mk - 1) % (mg + 1)) == 0);
                m = (cyc - 1 < mend) ? cyc - 1 : mend;
                if (m >= mk + 1) begin
                    e_emit = (m - mk - 1) / (mg + 1) + 1;
                    if (e_emit > mT) e_emit = mT;
                end
            end
            e_rdy = !Reset && !busy_m;
            chk("Req_ready", 64'(Req_ready), 64'(e_rdy));
            chk("En_o", 64'(En_o), 64'(e_en));
            chk("Busy", 64'(Busy), 64'(busy_m));
            chk("Done", 64'(Done), 64'(e_done));
            chk("Emitted", 64'(Emitted), 64'(e_emit));
            chk("Slt_o", 64'(Slt_o), 64'(rmode ? 1'b0 : mslt));
            if (En_o === 1'b1) begin
                en_n++;
                if (first_en < 0) first_en = cyc;
                if (Slt_o) s1++; else s0++;
            end
            if (Done === 1'b1) done_cyc = cyc;
            if (Reset) begin
                rmode = 1'b1;
            end else if (e_rdy && Req_valid) begin
                rmode = 1'b0;
                mk    = cyc;
                mT    = Req_slt ? (longint'(Req_count) << PL)
                                : longint'(Req_count);
                mg    = longint'(Req_gap);
                mslt  = Req_slt;
                mdone = (mT == 0) ? cyc + 1 : cyc + 1 + (mT - 1) * (mg + 1) + 1;
                mend  = mdone;
                acc_n++;
                acc_cyc  = cyc;
                first_en = -1;
                en_n     = 0;
            end else if (busy_m && Abort) begin
                mend = cyc;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic s, input logic [CW-1:0] n,
                        input logic [GW-1:0] g);
        int a0;
        bit ok;
        a0 = acc_n;
        ok = 1'b0;
        Req_slt   = s;
        Req_count = n;
        Req_gap   = g;
        Req_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (acc_n != a0) begin
                ok = 1'b1;
                break;
            end
        end
        Req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (Req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        longint k, a1, d0;
        int     b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // reset held mid-EMIT
        send(1'b0, 16'd20, 8'd0);
        repeat (3) tick();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", 64'(Req_ready), 64'd0);
            chk("rst_en", 64'(En_o), 64'd0);
            chk("rst_emitted", 64'(Emitted), 64'd0);
        end
        Reset = 1'b0;
        tick();
        chk("rst_release_ready", 64'(Req_ready), 64'd1);

        // direct channel, back-to-back
        b1 = s0;
        send(1'b0, 16'd3, 8'd0);
        k = acc_cyc;
        wait_idle();
        chk("t2_first", 64'(first_en - k), 64'd1);
        chk("t2_strobes", 64'(en_n), 64'd3);
        chk("t2_done", 64'(done_cyc - k), 64'd4);
        chk("t2_out0", 64'(s0 - b1), 64'd3);

        // prescaled channel with gap 1
        b1 = s1;
        send(1'b1, 16'd2, 8'd1);
        k = acc_cyc;
        wait_idle();
        chk("t3_first", 64'(first_en - k), 64'd1);
        chk("t3_strobes", 64'(en_n), 64'd8);
        chk("t3_done", 64'(done_cyc - k), 64'd16);
        chk("t3_out1", 64'((s1 - b1) >> PL), 64'd2);
        chk("t3_emitted", 64'(Emitted), 64'd8);

        // zero count on each channel
        for (int s = 0; s < 2; s++) begin
            send(s[0], 16'd0, 8'd2);
            k = acc_cyc;
            wait_idle();
            chk("t4_strobes", 64'(en_n), 64'd0);
            chk("t4_done", 64'(done_cyc - k), 64'd1);
            chk("t4_emitted", 64'(Emitted), 64'd0);
        end

        // abort after the second strobe
        d0 = done_cyc;
        send(1'b0, 16'd5, 8'd0);
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("t5_ready", 64'(Req_ready), 64'd1);
        chk("t5_emitted", 64'(Emitted), 64'd2);
        repeat (4) tick();
        chk("t5_strobes", 64'(en_n), 64'd2);
        chk("t5_no_done", 64'(done_cyc), 64'(d0));

        // valid held across two requests
        Req_slt   = 1'b1;
        Req_count = 16'd1;
        Req_gap   = 8'd0;
        Req_valid = 1'b1;
        b1 = acc_n;
        for (int i = 0; i < 50 && acc_n == b1; i++) tick();
        a1 = acc_cyc;
        Req_slt   = 1'b0;
        Req_count = 16'd2;
        Req_gap   = 8'd1;
        b1 = acc_n;
        for (int i = 0; i < 50 && acc_n == b1; i++) tick();
        Req_valid = 1'b0;
        chk("t6_second_accept", 64'(acc_cyc - a1), 64'd6);
        wait_idle();

        // randomized requests with random aborts and rare resets
        for (int it = 0; it < 80; it++) begin
            bit big;
            int age;
            big = ($urandom_range(0, 9) == 0);
            if (big)
                send(1'($urandom_range(0, 1)), 16'hC000, 8'($urandom_range(0, 2)));
            else
                send(1'($urandom_range(0, 1)), 16'($urandom_range(0, 6)),
                     8'($urandom_range(0, 3)));
            age = 0;
            for (int i = 0; i < 600 && !Req_ready; i++) begin
                Abort = ($urandom_range(0, 19) == 0) || (big && age > 12);
                Reset = ($urandom_range(0, 149) == 0);
                Req_valid = ($urandom_range(0, 3) == 0);
                tick();
                age++;
            end
            Abort = 1'b0;
            Reset = 1'b0;
            Req_valid = 1'b0;
            wait_idle();
            if ($urandom_range(0, 3) == 0) begin
                Abort = 1'b1;
                tick();
                Abort = 1'b0;
            end
        end

        repeat (3) tick();
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
